// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: combinational single-cycle ops plus an iterative multiply/divide
// engine that owns the architectural HI/LO registers and stalls the pipeline via Busy.
module alu_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [4:0]         ALUControl,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Start,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               SignBit,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO,
  output logic               Busy,
  output logic               Done
);

  // state | meaning
  // IDLE  | accepting ops; MTHI/MTLO write here
  // MUL   | shift-add iterations, one per cycle
  // DIV   | restoring-divide iterations, one per cycle
  // DONE  | HI/LO just written, Done pulses
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int CW = SHAMT_W + 1;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic             neg_q, neg_r, div_zero;

  logic             is_mul, is_div, signed_op, issue, last_iter;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_mul    = (ALUControl == 5'd8)  || (ALUControl == 5'd12);
  assign is_div    = (ALUControl == 5'd13) || (ALUControl == 5'd14);
  assign signed_op = (ALUControl == 5'd8)  || (ALUControl == 5'd13);
  assign issue     = Start && (state == IDLE);
  assign last_iter = (cnt == CW'(1));
  assign sign_a    = signed_op && A[WIDTH-1];
  assign sign_b    = signed_op && B[WIDTH-1];
  assign mag_a     = sign_a ? -A : A;
  assign mag_b     = sign_b ? -B : B;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (issue && is_mul)      state_n = MUL;
        else if (issue && is_div) state_n = DIV;
      end
      MUL, DIV: if (last_iter) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign Busy = (state == MUL) || (state == DIV);
  assign Done = (state == DONE);

  // One iteration of either engine; both share acc_hi/acc_lo/mcand.
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fin;
  logic [WIDTH-1:0]   q_fin, r_fin;

  always_comb begin
    add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    sub_diff = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, mcand};
    if (state == MUL) begin
      step_hi = add_sum[WIDTH:1];
      step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!sub_diff[WIDTH]) begin
      step_hi = sub_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      step_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
    prod     = {step_hi, step_lo};
    prod_fin = neg_q ? -prod : prod;
    // Divide by zero leaves the dividend magnitude as remainder, so the sign fix restores A.
    q_fin    = div_zero ? '1 : (neg_q ? -step_lo : step_lo);
    r_fin    = neg_r ? -step_hi : step_hi;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue && (is_mul || is_div)) begin
            cnt      <= CW'(WIDTH);
            acc_hi   <= '0;
            acc_lo   <= is_mul ? mag_b : mag_a;
            mcand    <= is_mul ? mag_a : mag_b;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= (B == '0);
          end else if (issue && ALUControl == 5'd17) begin
            HI <= A;
          end else if (issue && ALUControl == 5'd18) begin
            LO <= A;
          end
        end
        MUL, DIV: begin
          cnt    <= cnt - CW'(1);
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (last_iter) begin
            if (state == MUL) begin
              HI <= prod_fin[2*WIDTH-1:WIDTH];
              LO <= prod_fin[WIDTH-1:0];
            end else begin
              HI <= r_fin;
              LO <= q_fin;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      5'd0:  ALUResult = A + B;
      5'd1:  ALUResult = A - B;
      5'd2:  ALUResult = A & B;
      5'd3:  ALUResult = A | B;
      5'd4:  ALUResult = A ^ B;
      5'd5:  ALUResult = B << Shamt;
      5'd6:  ALUResult = B >> Shamt;
      5'd7:  ALUResult = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      5'd9:  ALUResult = ~(A | B);
      5'd10: ALUResult = WIDTH'($signed(B) >>> Shamt);
      5'd11: ALUResult = {{(WIDTH-1){1'b0}}, (A < B)};
      5'd15: ALUResult = HI;
      5'd16: ALUResult = LO;
      default: ALUResult = '0;
    endcase
  end

  assign Zero    = (ALUResult == '0);
  assign SignBit = ALUResult[WIDTH-1];

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: 32-bit instance for the bulk of checks,
// 16-bit instance for the narrow multiply.
module tb_alu_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  ALUControl = '0;
  logic [31:0] A = '0, B = '0;
  logic [4:0]  Shamt = '0;
  logic        Start = 1'b0;
  logic [31:0] ALUResult, HI, LO;
  logic        Zero, SignBit, Busy, Done;

  logic [4:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  sh16 = '0;
  logic        start16 = 1'b0;
  logic [15:0] res16, hi16, lo16;
  logic        zero16, sign16, busy16, done16;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  always #5 Clk = ~Clk;

  alu_muldiv_unit #(.WIDTH(32), .SHAMT_W(5)) u32 (
    .Clk(Clk), .Reset(Reset), .ALUControl(ALUControl), .A(A), .B(B), .Shamt(Shamt),
    .Start(Start), .ALUResult(ALUResult), .Zero(Zero), .SignBit(SignBit),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done));

  alu_muldiv_unit #(.WIDTH(16), .SHAMT_W(4)) u16 (
    .Clk(Clk), .Reset(Reset), .ALUControl(op16), .A(a16), .B(b16), .Shamt(sh16),
    .Start(start16), .ALUResult(res16), .Zero(zero16), .SignBit(sign16),
    .HI(hi16), .LO(lo16), .Busy(busy16), .Done(done16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic comb_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_r);
    @(negedge Clk);
    ALUControl = op; A = a; B = b; Shamt = sh;
    #1;
    chk(tag, ALUResult, exp_r);
    chk({tag, "_zero"}, Zero, exp_r == 32'h0);
    chk({tag, "_sign"}, SignBit, exp_r[31]);
  endtask

  // Issue an iterative op, watch MFHI during the run, compare on Done.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int busy_cnt = 0;
    int cyc = 0;
    bit got = 0;
    logic [63:0] e;
    sb_q.push_back({eh, el});
    @(negedge Clk);
    ALUControl = op; A = a; B = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; ALUControl = 5'd15; A = $urandom; B = $urandom;
    while (!got && cyc < 100) begin
      #1;
      if (Busy) busy_cnt++;
      if (Done) begin
        got = 1;
        e = sb_q.pop_front();
        chk({tag, "_hi"}, HI, e[63:32]);
        chk({tag, "_lo"}, LO, e[31:0]);
        chk({tag, "_mfhi"}, ALUResult, e[63:32]);
        chk({tag, "_busy_cycles"}, busy_cnt, 32);
        chk({tag, "_busy_in_done"}, Busy, 1'b0);
      end else begin
        @(negedge Clk);
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    @(negedge Clk);
    #1;
    chk({tag, "_idle_after"}, {Busy, Done}, 2'b00);
  endtask

  initial begin
    logic [63:0] e;
    int done_cnt;
    int bcnt;
    bit got;

    repeat (2) @(negedge Clk);
    #1;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy_done", {Busy, Done}, 2'b00);
    Reset = 1'b0;

    comb_op("add_wrap", 5'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000);
    comb_op("sub_zero", 5'd1, 32'h5, 32'h5, 5'd0, 32'h0);
    comb_op("and", 5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200);
    comb_op("or", 5'd3, 32'hF000_0001, 32'h0000_1000, 5'd0, 32'hF000_1001);
    comb_op("xor", 5'd4, 32'hFFFF_0000, 32'hF0F0_F0F0, 5'd0, 32'h0F0F_F0F0);
    comb_op("sll", 5'd5, 32'h0, 32'h0000_0003, 5'd31, 32'h8000_0000);
    comb_op("srl", 5'd6, 32'h0, 32'hF000_0000, 5'd4, 32'h0F00_0000);
    comb_op("slt", 5'd7, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1);
    comb_op("nor", 5'd9, 32'h0000_FFFF, 32'h00FF_0000, 5'd0, 32'hFF00_0000);
    comb_op("sra", 5'd10, 32'h0, 32'hF000_0000, 5'd4, 32'hFF00_0000);
    comb_op("sltu", 5'd11, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0);
    comb_op("undef_op", 5'd19, 32'h1234, 32'h5678, 5'd3, 32'h0);
    comb_op("mult_res0", 5'd8, 32'h1234, 32'h5678, 5'd0, 32'h0);

    @(negedge Clk);
    ALUControl = 5'd0; A = 32'h1; B = 32'h2; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    #1;
    chk("comb_start_no_busy", Busy, 1'b0);

    run_op("mult_neg", 5'd8, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 5'd12, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
    run_op("div_neg", 5'd13, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", 5'd14, 32'h40, 32'h0, 32'h00000040, 32'hFFFFFFFF);
    run_op("div_zero_signed", 5'd13, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_minneg", 5'd13, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("divu_big", 5'd14, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF);
    run_op("mult_pos_neg", 5'd8, 32'h00012345, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFEDCBB00);

    // MULT issued, DIV re-issued while busy and on the last busy cycle
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFDD});
    @(negedge Clk);
    ALUControl = 5'd8; A = 32'h7; B = 32'hFFFFFFFB; Start = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge Clk);
      Start = (c == 5 || c == 32);
      ALUControl = Start ? 5'd13 : 5'd15;
      A = 32'h100; B = 32'h3;
      #1;
      chk($sformatf("t4_busy_c%0d", c), Busy, (c <= 32));
      chk($sformatf("t4_done_c%0d", c), Done, (c == 33));
      if (c == 33) begin
        e = sb_q.pop_front();
        chk("t4_hi", HI, e[63:32]);
        chk("t4_lo", LO, e[31:0]);
        chk("t4_mfhi", ALUResult, e[63:32]);
      end
    end
    Start = 1'b0;

    // reset during a divide
    @(negedge Clk);
    ALUControl = 5'd13; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    #1;
    chk("rst_pre_busy", Busy, 1'b1);
    Reset = 1'b1;
    #1;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy_done", {Busy, Done}, 2'b00);
    @(negedge Clk);
    Reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      #1;
      if (Done || Busy) done_cnt++;
    end
    chk("rst_no_done", done_cnt, 0);
    run_op("mult_after_rst", 5'd8, 32'h3, 32'h4, 32'h0, 32'hC);

    // MTLO / MTHI
    @(negedge Clk);
    ALUControl = 5'd18; A = 32'h12345678; Start = 1'b1;
    #1;
    chk("mtlo_res0", ALUResult, 32'h0);
    @(negedge Clk);
    Start = 1'b0; ALUControl = 5'd16; A = 32'h0;
    #1;
    chk("mtlo_lo", LO, 32'h12345678);
    chk("mtlo_mflo", ALUResult, 32'h12345678);
    chk("mtlo_busy_done", {Busy, Done}, 2'b00);
    @(negedge Clk);
    ALUControl = 5'd17; A = 32'hCAFEF00D; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; ALUControl = 5'd15;
    #1;
    chk("mthi_hi", HI, 32'hCAFEF00D);
    chk("mthi_mfhi", ALUResult, 32'hCAFEF00D);
    chk("mthi_lo_kept", LO, 32'h12345678);
    chk("mthi_busy_done", {Busy, Done}, 2'b00);

    // 16-bit instance
    @(negedge Clk);
    op16 = 5'd8; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(negedge Clk);
    start16 = 1'b0; op16 = 5'd16;
    bcnt = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (busy16) bcnt++;
      if (done16) begin
        got = 1;
        chk("w16_hi", hi16, 16'h0000);
        chk("w16_lo", lo16, 16'h0001);
        chk("w16_mflo", res16, 16'h0001);
        chk("w16_busy_cycles", bcnt, 16);
      end else @(negedge Clk);
    end
    chk("w16_done_seen", got, 1'b1);
    op16 = 5'd0; a16 = 16'h7FFF; b16 = 16'h0001;
    #1;
    chk("w16_add", res16, 16'h8000);
    chk("w16_sign", sign16, 1'b1);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
